// File: rtl/collect_switch_seq_pkg.sv
// Shared definitions for the collect switch: command and source encodings.
// Same encodings are used by the distribute switch tree configuration.
package collect_switch_seq_pkg;

    localparam logic [1:0] CS_CMD_NA   = 2'b00;
    localparam logic [1:0] CS_CMD_LOW  = 2'b01;
    localparam logic [1:0] CS_CMD_HIGH = 2'b10;
    localparam logic [1:0] CS_CMD_BOTH = 2'b11;

    localparam logic [1:0] CS_SRC_NONE = 2'b00;
    localparam logic [1:0] CS_SRC_LOW  = 2'b01;
    localparam logic [1:0] CS_SRC_HIGH = 2'b10;
    localparam logic [1:0] CS_SRC_RED  = 2'b11;

    // Round-robin pick: rr_last is the index of the branch granted last.
    // On a tie the branch not granted last wins; a lone valid always wins.
    function automatic logic [1:0] rr_pick(
        input logic [1:0] valid,
        input logic       rr_last
    );
        logic [1:0] g;
        g = CS_SRC_NONE;
        case (valid)
            2'b01:   g = CS_SRC_LOW;
            2'b10:   g = CS_SRC_HIGH;
            2'b11:   g = rr_last ? CS_SRC_LOW : CS_SRC_HIGH;
            default: g = CS_SRC_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/collect_switch_seq_pipe_reg.sv
// pipe_reg_seq: one-entry valid/ready register used as the collect switch output stage.
// Loads when empty or when the held word is popped in the same cycle.
module pipe_reg_seq #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             load,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             ready
);

    assign load = !valid || ready;

    // Valid follows the push whenever the register may load; data holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= push;
            if (push) begin
                data <= push_data;
            end
        end
    end

endmodule

// File: rtl/collect_switch_seq.sv
// collect_switch_seq: merges low/high branch streams onto one registered output.
// Optional macro COLLECT_SWITCH_REDUCE_EN turns cmd=11 into a wrapping add of both branches.
module collect_switch_seq
    import collect_switch_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              i_valid,
    input  logic [2*DATA_WIDTH-1:0] i_data_bus,
    output logic [1:0]              o_ready,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data_bus,
    output logic [1:0]              o_src,
    input  logic                    i_ready,
    input  logic                    i_en,
    input  logic [1:0]              i_cmd
);

    localparam int PW = DATA_WIDTH + 2;

    logic [DATA_WIDTH-1:0] data_low;
    logic [DATA_WIDTH-1:0] data_high;
    logic [1:0]            grant;
    logic [1:0]            hs;
    logic                  load;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_word;
    logic [PW-1:0]         push_data;
    logic [PW-1:0]         out_data;

    assign data_low  = i_data_bus[DATA_WIDTH-1:0];
    assign data_high = i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];

`ifndef COLLECT_SWITCH_REDUCE_EN
    logic rr_last;
`endif

    // Branch grant from command, enable and arbitration state; data never involved.
    always_comb begin
        grant = CS_SRC_NONE;
        if (i_en) begin
            case (i_cmd)
                CS_CMD_LOW:  grant = CS_SRC_LOW;
                CS_CMD_HIGH: grant = CS_SRC_HIGH;
`ifdef COLLECT_SWITCH_REDUCE_EN
                CS_CMD_BOTH: grant = (i_valid == 2'b11) ? CS_SRC_RED : CS_SRC_NONE;
`else
                CS_CMD_BOTH: grant = rr_pick(i_valid, rr_last);
`endif
                default:     grant = CS_SRC_NONE;
            endcase
        end
    end

    assign o_ready = (rst_n && load) ? grant : 2'b00;
    assign hs      = o_ready & i_valid;
    assign push    = (hs != 2'b00);

    // Select (or reduce) the accepted branch word; hs doubles as the source tag.
    always_comb begin
        push_word = '0;
        case (hs)
            2'b01:   push_word = data_low;
            2'b10:   push_word = data_high;
`ifdef COLLECT_SWITCH_REDUCE_EN
            2'b11:   push_word = data_low + data_high;
`endif
            default: push_word = '0;
        endcase
    end

    assign push_data = {hs, push_word};

`ifndef COLLECT_SWITCH_REDUCE_EN
    // Remember which branch won the last serialized handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (i_cmd == CS_CMD_BOTH) begin
            if (hs == CS_SRC_LOW) begin
                rr_last <= 1'b0;
            end else if (hs == CS_SRC_HIGH) begin
                rr_last <= 1'b1;
            end
        end
    end
`endif

    pipe_reg_seq #(
        .WIDTH (PW)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .load      (load),
        .valid     (o_valid),
        .data      (out_data),
        .ready     (i_ready)
    );

    assign o_src      = out_data[PW-1:DATA_WIDTH];
    assign o_data_bus = out_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_collect_switch_seq.sv
// Directed bench for collect_switch_seq with hand-computed expectations.
// Build with COLLECT_SWITCH_REDUCE_EN defined to cover the reduce variant.
module tb_collect_switch_seq;

    logic        clk;
    logic        rst_n;
    logic [1:0]  i_valid;
    logic [63:0] i_data_bus;
    logic [1:0]  o_ready;
    logic        o_valid;
    logic [31:0] o_data_bus;
    logic [1:0]  o_src;
    logic        i_ready;
    logic        i_en;
    logic [1:0]  i_cmd;

    int vectors;
    int miscompares;

    collect_switch_seq #(
        .DATA_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_src      (o_src),
        .i_ready    (i_ready),
        .i_en       (i_en),
        .i_cmd      (i_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs may then be changed at posedge+1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        i_valid     = 2'b11;
        i_cmd       = 2'b11;
        i_en        = 1'b1;
        i_ready     = 1'b1;
        i_data_bus  = {32'd2, 32'd1};

        step();
        step();
        settle();
        chk("rst_ready", 64'(o_ready), 64'(2'b00));
        chk("rst_valid", 64'(o_valid), 64'(1'b0));
        chk("rst_data", 64'(o_data_bus), 64'h0);
        chk("rst_src", 64'(o_src), 64'(2'b00));

        rst_n = 1'b1;
        settle();
`ifdef COLLECT_SWITCH_REDUCE_EN
        chk("red_ready", 64'(o_ready), 64'(2'b11));
        step();
        settle();
        chk("red_data", 64'(o_data_bus), 64'd3);
        chk("red_src", 64'(o_src), 64'(2'b11));
        i_data_bus = {32'd2, 32'hFFFF_FFFF};
        step();
        settle();
        chk("red_wrap_data", 64'(o_data_bus), 64'h1);
        chk("red_wrap_src", 64'(o_src), 64'(2'b11));
        i_valid = 2'b01;
        settle();
        chk("red_low_only", 64'(o_ready), 64'(2'b00));
        step();
        settle();
        chk("red_low_only_drain", 64'(o_valid), 64'(1'b0));
`else
        chk("ser_first_grant", 64'(o_ready), 64'(2'b01));
        for (int i = 0; i < 4; i++) begin
            step();
            settle();
            chk("ser_valid", 64'(o_valid), 64'(1'b1));
            chk("ser_data", 64'(o_data_bus), (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("ser_src", 64'(o_src), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
        end
`endif

        i_cmd      = 2'b01;
        i_valid    = 2'b11;
        i_data_bus = {32'h5A, 32'hA5};
        settle();
        chk("low_ready", 64'(o_ready), 64'(2'b01));
        step();
        settle();
        chk("low_data", 64'(o_data_bus), 64'hA5);
        chk("low_src", 64'(o_src), 64'(2'b01));
        chk("low_ready_again", 64'(o_ready), 64'(2'b01));

        i_ready    = 1'b0;
        i_data_bus = {32'h5A, 32'h11};
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ready", 64'(o_ready), 64'(2'b00));
            chk("bp_valid", 64'(o_valid), 64'(1'b1));
            chk("bp_data", 64'(o_data_bus), 64'hA5);
            step();
        end
        i_ready = 1'b1;
        settle();
        chk("bp_release_ready", 64'(o_ready), 64'(2'b01));
        step();
        settle();
        chk("bp_reload_data", 64'(o_data_bus), 64'h11);
        chk("bp_reload_valid", 64'(o_valid), 64'(1'b1));

        i_en    = 1'b0;
        i_ready = 1'b0;
        settle();
        chk("dis_ready", 64'(o_ready), 64'(2'b00));
        step();
        settle();
        chk("dis_hold_valid", 64'(o_valid), 64'(1'b1));
        i_ready = 1'b1;
        settle();
        chk("dis_ready_drain", 64'(o_ready), 64'(2'b00));
        step();
        settle();
        chk("dis_popped", 64'(o_valid), 64'(1'b0));
        chk("dis_data_held", 64'(o_data_bus), 64'h11);

        i_en  = 1'b1;
        i_cmd = 2'b00;
        settle();
        chk("na_ready", 64'(o_ready), 64'(2'b00));

        i_cmd = 2'b10;
        settle();
        chk("high_ready", 64'(o_ready), 64'(2'b10));
        step();
        settle();
        chk("high_data", 64'(o_data_bus), 64'h5A);
        chk("high_src", 64'(o_src), 64'(2'b10));

        i_ready = 1'b0;
        rst_n   = 1'b0;
        settle();
        chk("midrst_ready", 64'(o_ready), 64'(2'b00));
        step();
        settle();
        chk("midrst_valid", 64'(o_valid), 64'(1'b0));
        chk("midrst_data", 64'(o_data_bus), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
